// File: rtl/jtframe_shram_arb.sv
// N-port arbiter owning a single-port shared RAM: one owner at a time, per-port
// wait (busy) outputs, latched read data and optional preemption of long holders.
module jtframe_shram_arb #(
    parameter int NPORT   = 2,
    parameter int AW      = 13,
    parameter int DW      = 8,
    parameter int RROBIN  = 0,
    parameter int MAXHOLD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    cs,
    input  logic [NPORT-1:0]    rnw,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*DW-1:0] din,
    output logic [NPORT*DW-1:0] dout,
    output logic [NPORT-1:0]    busy,
    output logic [NPORT-1:0]    grant,
    output logic [7:0]          st_dout
);

    localparam int          IW   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned NP   = NPORT;
    localparam logic [7:0]  MAXH = 8'(MAXHOLD);

    typedef enum logic { ST_IDLE, ST_OWNED } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NPORT-1:0] grant_d;
    logic [IW-1:0]   ptr_q;
    logic [7:0]      hold_q;
    logic            preempt_seen_q;
    logic            valid_q;
    logic [AW-1:0]   lat_addr_q;
    logic            lat_rnw_q;
    logic [DW-1:0]   q_q;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    logic            owned, cur_cs, cur_rnw, valid_eff, preempt, keep, new_grant;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   cur_din;
    logic [NPORT-1:0] cand;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    int unsigned     idx;
    logic            we;

    // state register and per-owner bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grant          <= '0;
            owner_q        <= '0;
            ptr_q          <= '0;
            hold_q         <= '0;
            preempt_seen_q <= 1'b0;
            valid_q        <= 1'b0;
            lat_addr_q     <= '0;
            lat_rnw_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant      <= grant_d;
            owner_q    <= owner_d;
            lat_addr_q <= cur_addr;
            lat_rnw_q  <= cur_rnw;
            if (new_grant) begin
                ptr_q   <= (win_idx == IW'(NPORT-1)) ? '0 : win_idx + 1'b1;
                hold_q  <= 8'd1;
                valid_q <= 1'b0;
            end else if (keep) begin
                hold_q  <= (hold_q == 8'hff) ? 8'hff : hold_q + 8'd1;
                valid_q <= 1'b1;
            end else begin
                hold_q  <= '0;
                valid_q <= 1'b0;
            end
            if (preempt) preempt_seen_q <= 1'b1;
        end
    end

    // next-state: keep owner, hand over, or go idle
    always_comb begin
        owned    = (state_q == ST_OWNED);
        cur_cs   = cs[owner_q];
        cur_rnw  = rnw[owner_q];
        cur_addr = addr[owner_q*AW +: AW];
        cur_din  = din[owner_q*DW +: DW];
        preempt  = (MAXHOLD != 0) && owned && cur_cs && (hold_q >= MAXH)
                   && |(cs & ~grant);
        keep     = owned && cur_cs && !preempt;
        cand     = owned ? (cs & ~grant) : cs;

        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NP; k++) begin
            idx = (RROBIN != 0) ? (32'(ptr_q) + k) % NP : k;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end

        state_d   = ST_IDLE;
        owner_d   = owner_q;
        grant_d   = '0;
        new_grant = 1'b0;
        if (keep) begin
            state_d = ST_OWNED;
            grant_d = grant;
        end else if (win_found) begin
            state_d          = ST_OWNED;
            owner_d          = win_idx;
            grant_d[win_idx] = 1'b1;
            new_grant        = 1'b1;
        end
    end

    // outputs: valid holds only while the owner's address and direction match
    // what was presented on the previous owned cycle
    always_comb begin
        valid_eff = owned && valid_q && (cur_addr == lat_addr_q) && (cur_rnw == lat_rnw_q);
        we        = owned && !cur_rnw;
        busy      = cs & ~(grant & {NPORT{valid_eff && !rst}});
        st_dout   = {preempt_seen_q, 1'b0, valid_eff, 2'b00, 3'(owner_q)};
    end

    always_ff @(posedge clk) begin
        if (we) mem[cur_addr] <= cur_din;
        q_q <= mem[cur_addr];
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NP; i++) begin
            if (rst)
                dout[i*DW +: DW] <= '0;
            else if (grant[i] && valid_eff && rnw[i])
                dout[i*DW +: DW] <= q_q;
        end
    end

endmodule
